// File: rtl/phy_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_sched_pkg
//  Description : Shared constants and encodings for the TX byte-slot scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_sched_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam int         SLOT_BITS = 8;
  localparam int         PHASE_W   = 3;

  localparam logic [PHASE_W-1:0] PHASE_FIRST = '0;
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(SLOT_BITS - 1);

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } lane_state_t;

  typedef enum logic [0:0] {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage : phy_tx_sched_pkg
`default_nettype wire

// File: rtl/phy_tx_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_rr_arb2
//  Description : Two-requester round-robin arbiter; grants only while en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_rr_arb2
  import phy_tx_sched_pkg::*;
(
  input  logic   clk_32f,
  input  logic   reset,
  input  logic   en,
  input  logic   req_a,
  input  logic   req_b,
  output logic   gnt_a,
  output logic   gnt_b,
  output grant_t winner
);

  grant_t r_last_grant;
  logic   w_pick_a;

  // A wins when alone, or on a tie when B was served last.
  always_comb begin
    w_pick_a = req_a & (~req_b | (r_last_grant == GRANT_B));
    gnt_a    = en & w_pick_a;
    gnt_b    = en & req_b & ~w_pick_a;
    winner   = w_pick_a ? GRANT_A : GRANT_B;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_last_grant <= GRANT_B;
    end else if (gnt_a | gnt_b) begin
      r_last_grant <= winner;
    end
  end

endmodule : phy_tx_rr_arb2
`default_nettype wire

// File: rtl/phy_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_sched
//  Description : Byte-slot scheduler feeding the TX serializer; COM sync then RR.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_sched
  import phy_tx_sched_pkg::*;
#(
  parameter int SYNC_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [7:0]       data_a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [7:0]       data_b,
  input  logic             valid_b,
  output logic             ready_b,
  input  logic             resync,
  output logic [7:0]       ser_data,
  output logic             ser_valid,
  output logic             slot_start,
  output logic             lane_active,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  logic [PHASE_W-1:0] r_phase;
  lane_state_t        r_state;
  logic [3:0]         r_sync_cnt;
  logic               r_resync_pend;
  logic [7:0]         r_ser_data;
  logic               r_ser_valid;
  logic [CNT_W-1:0]   r_bytes_sent;

  lane_state_t        w_state_nxt;
  logic [3:0]         w_sync_cnt_nxt;
  logic               w_resync_pend_nxt;
  logic [7:0]         w_ser_data_nxt;
  logic               w_ser_valid_nxt;
  logic [CNT_W-1:0]   w_bytes_sent_nxt;

  logic               w_boundary;
  logic               w_resync_now;
  logic               w_sync_done;
  logic               w_grant_ok;
  logic               w_gnt_a;
  logic               w_gnt_b;
  logic               w_granted;
  grant_t             w_winner;
  logic [7:0]         w_grant_data;

  always_comb begin
    w_boundary   = (r_phase == PHASE_LAST);
    w_resync_now = r_resync_pend | resync;
    w_sync_done  = (r_state == SYNC) && (r_sync_cnt == SYNC_LAST);
    // Gating with reset keeps both ready lines low while reset is held.
    w_grant_ok   = w_boundary & ((r_state == ACTIVE) | w_sync_done)
                   & ~w_resync_now & ~reset;
  end

  phy_tx_rr_arb2 u_arb (
    .clk_32f (clk_32f),
    .reset   (reset),
    .en      (w_grant_ok),
    .req_a   (valid_a),
    .req_b   (valid_b),
    .gnt_a   (w_gnt_a),
    .gnt_b   (w_gnt_b),
    .winner  (w_winner)
  );

  assign w_granted    = w_gnt_a | w_gnt_b;
  assign w_grant_data = (w_winner == GRANT_A) ? data_a : data_b;

  always_comb begin
    w_state_nxt       = r_state;
    w_sync_cnt_nxt    = r_sync_cnt;
    w_resync_pend_nxt = r_resync_pend | resync;
    w_ser_data_nxt    = r_ser_data;
    w_ser_valid_nxt   = r_ser_valid;
    w_bytes_sent_nxt  = r_bytes_sent;

    if (w_boundary) begin
      w_resync_pend_nxt = 1'b0;
      if (w_resync_now) begin
        w_state_nxt     = SYNC;
        w_sync_cnt_nxt  = '0;
        w_ser_valid_nxt = 1'b0;
        w_ser_data_nxt  = K28_5_COM;
      end else begin
        if (r_state == SYNC) begin
          if (w_sync_done) begin
            w_state_nxt    = ACTIVE;
            w_sync_cnt_nxt = '0;
          end else begin
            w_sync_cnt_nxt = r_sync_cnt + 4'd1;
          end
        end
        if (w_granted) begin
          w_ser_data_nxt   = w_grant_data;
          w_ser_valid_nxt  = 1'b1;
          w_bytes_sent_nxt = r_bytes_sent + CNT_W'(1);
        end else begin
          w_ser_data_nxt   = K28_5_COM;
          w_ser_valid_nxt  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_phase       <= PHASE_FIRST;
      r_state       <= SYNC;
      r_sync_cnt    <= '0;
      r_resync_pend <= 1'b0;
      r_ser_data    <= K28_5_COM;
      r_ser_valid   <= 1'b0;
      r_bytes_sent  <= '0;
    end else begin
      r_phase       <= r_phase + PHASE_W'(1);
      r_state       <= w_state_nxt;
      r_sync_cnt    <= w_sync_cnt_nxt;
      r_resync_pend <= w_resync_pend_nxt;
      r_ser_data    <= w_ser_data_nxt;
      r_ser_valid   <= w_ser_valid_nxt;
      r_bytes_sent  <= w_bytes_sent_nxt;
    end
  end

  assign ready_a     = w_gnt_a;
  assign ready_b     = w_gnt_b;
  assign ser_data    = r_ser_data;
  assign ser_valid   = r_ser_valid;
  assign slot_start  = (r_phase == PHASE_FIRST);
  assign lane_active = (r_state == ACTIVE);
  assign bytes_sent  = r_bytes_sent;

endmodule : phy_tx_sched
`default_nettype wire

// File: doc/phy_tx_sched.md
Name: phy_tx_sched

Overview:
- Byte-slot scheduler in front of the TX parallel-to-serial converter on the clk_32f domain.
- Two byte sources (A: payload, B: control/ordered-sets) share one serial lane.
- After reset or a resync request, the block emits SYNC_BYTES idle/COM slots. It then grants one requester per 8-cycle byte slot, round-robin, and drives the serializer's data_in/valid_in, holding them stable for the full slot.

Parameters:
- SYNC_BYTES, 4, number of COM (8'hBC) slots sent after reset or resync before any grant; legal range 1..15.
- CNT_W, 16, width of the transmitted-data-byte counter.

Ports:
- clk_32f  in  1  bit clock, same as serializer.
- reset  in  1  synchronous, active-high reset; serializer reset_L is driven from ~reset so both phase counters align.
- data_a  in  8  byte from requester A.
- valid_a  in  1  A has a byte.
- ready_a  out  1  A's byte is consumed this cycle (valid_a & ready_a = transfer).
- data_b  in  8  byte from requester B.
- valid_b  in  1  B has a byte.
- ready_b  out  1  B's byte is consumed this cycle.
- resync  in  1  single-cycle request to re-enter SYNC.
- ser_data  out  8  to serializer data_in.
- ser_valid  out  1  to serializer valid_in; 0 means serializer sends 8'hBC.
- slot_start  out  1  high when phase==0 (first bit of a slot).
- lane_active  out  1  high in ACTIVE state.
- bytes_sent  out  CNT_W  count of data bytes granted; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (reset high at a clk_32f edge):
  - phase=0, state=SYNC, sync_cnt=0, resync_pend=0.
  - ser_data=8'hBC, ser_valid=0, lane_active=0, bytes_sent=0.
  - last_grant=B, so A wins the first tie.
  - ready_a=ready_b=0 while reset is high.
- Phase counter:
  - 3-bit; increments every cycle and wraps 7->0.
  - Slot boundary = cycle with phase==7. All state/output updates except the phase counter happen only there; ser_data/ser_valid are constant for 8 cycles.
- grant_ok = (phase==7) & (state==ACTIVE | (state==SYNC & sync_cnt==SYNC_BYTES-1)) & ~resync_pend & ~resync.
- Arbitration when grant_ok:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the one not equal to last_grant.
  - ready_x is combinational: grant_ok & valid_x & selected. The requester's data must be stable while valid is high.
- On a grant (registered at the phase-7 edge):
  - ser_data <= granted data, ser_valid <= 1, last_grant <= granted, bytes_sent += 1.
  - Latency: byte is on ser_data from the following phase-0 cycle.
- No grant at a boundary: ser_valid <= 0 and ser_data <= 8'hBC (idle slot). last_grant is unchanged.
- State SYNC:
  - ser_valid=0 throughout.
  - At each boundary, sync_cnt += 1.
  - At the boundary with sync_cnt==SYNC_BYTES-1: state <= ACTIVE, sync_cnt <= 0, and that same boundary may grant.
  - Exactly SYNC_BYTES COM slots are sent; the first data byte appears at cycle 8*SYNC_BYTES after reset release (cycle 32 for the default).
- State ACTIVE: grants per the rules above.
- resync:
  - A pulse in any cycle sets resync_pend; a pulse on a boundary cycle counts too.
  - At the next boundary: state <= SYNC, sync_cnt <= 0, ser_valid <= 0, ser_data <= 8'hBC, resync_pend <= 0, no grant.
  - A slot already in flight completes unmodified.
  - resync during SYNC restarts the COM count.
- lane_active = (state==ACTIVE), registered.
- Reset mid-slot: everything returns to reset values at that edge. Any partially serialized byte is abandoned, and the requester's handshake already completed is not repeated.

Decomposition:
- Shared package constants: K28_5_COM=8'hBC, SLOT_BITS=8, PHASE_W=3, state encoding (SYNC=1'b0, ACTIVE=1'b1), GRANT_A/GRANT_B encodings.
- One natural sub-module: phy_tx_rr_arb2, a two-requester round-robin with last_grant register and enable input.
- Phase counter, SYNC/ACTIVE FSM and output registers stay in the top.

Test Plan:
- Reset, valid_a held 1 with data_a=8'h11, SYNC_BYTES=4 -> ser_valid=0 for cycles 0..31; ready_a pulses at cycle 31; ser_data=8'h11, ser_valid=1 for cycles 32..39; serial stream shows four 8'hBC bytes then 8'h11.
- Both valid continuously (A=8'hA0, B=8'hB0) in ACTIVE -> slots alternate A0,B0,A0,B0 starting with A0; bytes_sent increments by 1 per slot; each ready is high one cycle per slot.
- No requester valid for 3 slots in ACTIVE -> ser_valid=0, ser_data=8'hBC for 24 cycles; bytes_sent unchanged; next valid_b byte 8'h3C granted at the next phase 7.
- resync pulse at phase 3 of a slot carrying 8'h55 -> 8'h55 completes all 8 bits; then 4 COM slots; ready stays 0 during that time; lane_active=0; grants resume at the boundary ending the 4th COM slot.
- Reset asserted at phase 5 of a data slot -> next cycle ser_valid=0, ser_data=8'hBC, bytes_sent=0, phase=0, state=SYNC; no ready for the following 31 cycles.
- bytes_sent at 16'hFFFF, one more grant -> bytes_sent=16'h0000, no other effect.
